ahb_sram: RTL and testbench
===========================

// Module: ahb_sram
// PURPOSE
//  AHB-Lite slave bridge onto a single-port synchronous SRAM macro (word-wide, byte-writable).
//  Sits as slave S1 on the system AHB bus, beside the QSPI XIP flash controller and the SPM.
//  Zero-wait-state writes and reads; one wait state only for a read that directly follows a write.
// PARAMETERS
//  AW  14  byte-address bits decoded; SRAMADDR = word address = HADDR[AW-1:2] (12 bits, 16 KiB)
// PORTS
//  HCLK       in   1   bus clock; all state on rising edge
//  HRESETn    in   1   reset; asynchronous, ACTIVE-HIGH (codebase name retained)
//  HSEL       in   1   slave select from bus decoder
//  HADDR      in   32  address; only [AW-1:0] used
//  HREADY     in   1   bus-wide ready (transfer accepted when high)
//  HWRITE     in   1   1 = write
//  HTRANS     in   2   transfer type; HTRANS[1]=1 (NONSEQ/SEQ) is a valid transfer
//  HSIZE      in   3   0=byte, 1=halfword, 2=word
//  HWDATA     in   32  write data (data phase)
//  HRDATA     out  32  read data
//  HREADYOUT  out  1   slave ready
//  SRAMRDATA  in   32  SRAM read data, valid the cycle after a read access
//  SRAMWEN    out  4   per-byte write enable, active-high, bit i -> byte lane i
//  SRAMWDATA  out  32  SRAM write data
//  SRAMCS0    out  1   SRAM chip select, active-high
//  SRAMADDR   out  12  SRAM word address
// BEHAVIOUR
//  - valid = HSEL & HREADY & HTRANS[1]; no HRESP output (always OKAY); HSIZE>2 treated as word.
//  - Byte-lane mask: byte -> 1<<HADDR[1:0]; half -> HADDR[1]?4'b1100:4'b0011; word -> 4'b1111.
//  - Write: valid & HWRITE at cycle T registers wr_pend=1, word address, lane mask.
//    At T+1 (data phase): SRAMCS0=1, SRAMADDR=reg addr, SRAMWEN=mask, SRAMWDATA=HWDATA, HREADYOUT=1.
//    wr_pend clears after T+1 unless a new write is accepted at T+1 (back-to-back writes, no stall).
//  - Read, no pending write: valid & !HWRITE at T: SRAMCS0=1, SRAMWEN=0, SRAMADDR=HADDR[AW-1:2]
//    (combinational); at T+1 HRDATA=SRAMRDATA, HREADYOUT=1.
//  - Read following write (read accepted while wr_pend=1): write takes the port at T; read marked
//    rd_defer. T+1: SRAMCS0=1, SRAMADDR=registered read addr, SRAMWEN=0, HREADYOUT=0.
//    T+2: HRDATA=SRAMRDATA, HREADYOUT=1. Read returns the just-written data.
//  - Priority on the SRAM port: pending write > deferred read > new read.
//  - HRDATA = SRAMRDATA at all times (only sampled by master when HREADYOUT=1 in a read data phase).
//  - Idle cycles (no valid, nothing pending): SRAMCS0=0, SRAMWEN=0; SRAMADDR/SRAMWDATA don't-care.
//  - HSEL low / IDLE / BUSY transfers: no SRAM access, HREADYOUT=1.
//  - Reset (HRESETn=1, async): wr_pend=0, rd_defer=0, regs 0; HREADYOUT=1, SRAMCS0=0, SRAMWEN=0.
//    Reset mid-transfer discards any pending write (no SRAM write after reset).
// TESTING
//  1 Word write 0xDEADBEEF @0x0000_0010, then read @0x10 -> write cycle SRAMADDR=4, SRAMWEN=4'hF;
//    read returns 0xDEADBEEF with exactly one wait state (HREADYOUT=0 one cycle).
//  2 Byte writes 0x11,0x22,0x33,0x44 to 0x20..0x23 back-to-back -> SRAMWEN 1,2,4,8, no stalls;
//    after idle, word read @0x20 -> 0x44332211, zero wait states.
//  3 Halfword write 0xABCD @0x32 over word 0 -> SRAMWEN=4'b1100; read @0x30 -> 0xABCD0000.
//  4 Back-to-back reads @0x0,0x4,0x8 -> one SRAM access per cycle, HREADYOUT constantly 1.
//  5 HSEL=0 or HTRANS=IDLE with HWRITE=1 -> SRAMCS0=0, SRAMWEN=0, memory unchanged.
//  6 Assert HRESETn in write data phase -> SRAMWEN=0 immediately, HREADYOUT=1, word unchanged.

Source files
------------

// File: rtl/ahb_sram_if.sv
// AHB-Lite signal bundle between the bus fabric and the ahb_sram slave.
interface ahb_sram_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HREADY;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport master (
    output HSEL, HADDR, HREADY, HWRITE, HTRANS, HSIZE, HWDATA,
    input  HRDATA, HREADYOUT
  );

  modport slave (
    input  HSEL, HADDR, HREADY, HWRITE, HTRANS, HSIZE, HWDATA,
    output HRDATA, HREADYOUT
  );
endinterface

// File: rtl/ahb_sram.sv
// AHB-Lite slave bridge onto a single-port, byte-writable synchronous SRAM.
// Zero-wait writes/reads; a read landing in a write data phase costs one wait state.
module ahb_sram #(
  parameter int unsigned AW = 14
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  ahb_sram_if.slave     ahb,
  input  logic [31:0]   SRAMRDATA,
  output logic [3:0]    SRAMWEN,
  output logic [31:0]   SRAMWDATA,
  output logic          SRAMCS0,
  output logic [AW-3:0] SRAMADDR
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_RD_STALL
  } state_t;

  state_t        state;
  logic [AW-3:0] wr_addr;
  logic [AW-3:0] rd_addr;
  logic [3:0]    wr_mask;

  logic          valid;
  logic [AW-3:0] haddr_word;
  logic [3:0]    lane_mask;
  logic          unused_bits;

  assign valid       = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign haddr_word  = ahb.HADDR[AW-1:2];
  assign unused_bits = ^{ahb.HADDR[31:AW], ahb.HTRANS[0]};

  always_comb begin
    unique case (ahb.HSIZE)
      3'd0:    lane_mask = 4'b0001 << ahb.HADDR[1:0];
      3'd1:    lane_mask = ahb.HADDR[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = '1;
    endcase
  end

  // The old wr_pend/rd_defer flag pair is one-hot here: a read arriving in a
  // write data phase leaves no write pending, and no transfer is accepted while
  // the deferred read holds HREADYOUT low.
  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      state   <= ST_IDLE;
      wr_addr <= '0;
      wr_mask <= '0;
      rd_addr <= '0;
    end else begin
      state <= ST_IDLE;
      if (valid && ahb.HWRITE) begin
        state   <= ST_WR_DATA;
        wr_addr <= haddr_word;
        wr_mask <= lane_mask;
      end else if (valid && state == ST_WR_DATA) begin
        state   <= ST_RD_STALL;
        rd_addr <= haddr_word;
      end
    end
  end

  // Port priority: pending write, then deferred read, then a fresh read.
  always_comb begin
    SRAMCS0   = 1'b0;
    SRAMWEN   = '0;
    SRAMADDR  = haddr_word;
    SRAMWDATA = ahb.HWDATA;
    unique case (state)
      ST_WR_DATA: begin
        SRAMCS0  = 1'b1;
        SRAMWEN  = wr_mask;
        SRAMADDR = wr_addr;
      end
      ST_RD_STALL: begin
        SRAMCS0  = 1'b1;
        SRAMADDR = rd_addr;
      end
      default: begin
        if (valid && !ahb.HWRITE) begin
          SRAMCS0 = 1'b1;
        end
      end
    endcase
  end

  assign ahb.HRDATA    = SRAMRDATA;
  assign ahb.HREADYOUT = (state != ST_RD_STALL);

endmodule

// File: tb/tb_ahb_sram.sv
// Bench for ahb_sram: directed scenarios plus random AHB traffic against a
// transfer-level memory model, with an SRAM macro model behind the DUT.
module tb_ahb_sram;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] sram_rdata;
  logic [3:0]  sram_wen;
  logic [31:0] sram_wdata;
  logic        sram_cs;
  logic [11:0] sram_addr;

  ahb_sram_if bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_sram #(.AW(14)) dut (
    .HCLK      (clk),
    .HRESETn   (rst),
    .ahb       (bus),
    .SRAMRDATA (sram_rdata),
    .SRAMWEN   (sram_wen),
    .SRAMWDATA (sram_wdata),
    .SRAMCS0   (sram_cs),
    .SRAMADDR  (sram_addr)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM macro: read data appears the cycle after the access.
  logic [31:0] sram [0:4095];
  logic        sram_init = 1'b0;
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < 4096; i++) sram[i] <= '0;
      sram_init  <= 1'b1;
      sram_rdata <= '0;
    end else if (sram_cs) begin
      if (sram_wen != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wen[b]) sram[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end else begin
        sram_rdata <= sram[sram_addr];
      end
    end
  end

  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endfunction

  function automatic logic [3:0] lanes(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] m;
    m = '0;
    if (size == 3'd0) m[a] = 1'b1;
    else if (size == 3'd1) m = a[1] ? 4'hC : 4'h3;
    else m = 4'hF;
    return m;
  endfunction

  // Observations gathered by the compare process for the directed literal checks.
  int          stall_seen = 0;
  int          rdacc_cnt  = 0;
  int          cs_cnt     = 0;
  logic [15:0] wen_log    = '0;
  logic [31:0] last_rdata = '0;
  logic [11:0] obs_waddr  = '0;
  logic [3:0]  obs_wen    = '0;

  logic [7:0] ref_mem [0:4095][0:3];

  task automatic monitor();
    logic        m_wr    = 1'b0;
    logic        m_stall = 1'b0;
    logic        m_rd    = 1'b0;
    logic        m_rd_next;
    logic [11:0] m_waddr = '0;
    logic [11:0] m_raddr = '0;
    logic [3:0]  m_wmask = '0;
    logic        exp_ready, v, e_cs;
    logic [3:0]  e_wen;
    logic [11:0] e_addr;
    logic [31:0] word;
    for (int i = 0; i < 4096; i++)
      for (int b = 0; b < 4; b++) ref_mem[i][b] = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.HREADYOUT === 1'b0) stall_seen++;
      if (sram_cs) cs_cnt++;
      if (sram_cs && sram_wen == 4'h0) rdacc_cnt++;
      if (sram_wen != 4'h0) begin
        wen_log   = {wen_log[11:0], sram_wen};
        obs_waddr = sram_addr;
        obs_wen   = sram_wen;
      end
      if (rst) begin
        chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        chk("rst_cs", 32'(sram_cs), 32'd0);
        chk("rst_wen", 32'(sram_wen), 32'd0);
        m_wr = 1'b0; m_stall = 1'b0; m_rd = 1'b0;
      end else begin
        exp_ready = !m_stall;
        v = bus.HSEL && exp_ready && bus.HTRANS[1];
        chk("hreadyout", 32'(bus.HREADYOUT), 32'(exp_ready));
        if (m_rd && exp_ready) begin
          word = {ref_mem[m_raddr][3], ref_mem[m_raddr][2], ref_mem[m_raddr][1], ref_mem[m_raddr][0]};
          chk("hrdata", bus.HRDATA, word);
          last_rdata = bus.HRDATA;
        end
        if (m_wr) begin
          e_cs = 1'b1; e_wen = m_wmask; e_addr = m_waddr;
        end else if (m_stall) begin
          e_cs = 1'b1; e_wen = 4'h0; e_addr = m_raddr;
        end else if (v && !bus.HWRITE) begin
          e_cs = 1'b1; e_wen = 4'h0; e_addr = bus.HADDR[13:2];
        end else begin
          e_cs = 1'b0; e_wen = 4'h0; e_addr = '0;
        end
        chk("sram_cs", 32'(sram_cs), 32'(e_cs));
        chk("sram_wen", 32'(sram_wen), 32'(e_wen));
        if (e_cs) chk("sram_addr", 32'(sram_addr), 32'(e_addr));
        if (e_wen != 4'h0) chk("sram_wdata", sram_wdata, bus.HWDATA);
        if (m_wr)
          for (int b = 0; b < 4; b++)
            if (m_wmask[b]) ref_mem[m_waddr][b] = bus.HWDATA[b*8 +: 8];
        m_rd_next = (v && !bus.HWRITE) || m_stall;
        if (v && !bus.HWRITE) m_raddr = bus.HADDR[13:2];
        m_stall = v && !bus.HWRITE && m_wr;
        m_rd    = m_rd_next;
        m_wr    = v && bus.HWRITE;
        if (m_wr) begin
          m_waddr = bus.HADDR[13:2];
          m_wmask = lanes(bus.HSIZE, bus.HADDR[1:0]);
        end
      end
    end
  endtask

  // Present one address phase, hold it until accepted, then drive its write data.
  task automatic bus_cycle(input logic sel, input logic [1:0] trans, input logic wr,
                           input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    logic        acc;
    int unsigned n;
    bus.HSEL = sel; bus.HTRANS = trans; bus.HWRITE = wr;
    bus.HADDR = addr; bus.HSIZE = size;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 16) begin
      @(negedge clk);
      acc = bus.HREADYOUT;
      @(posedge clk);
      #1;
      n++;
    end
    chk("bus_accept", 32'(acc), 32'd1);
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
    if (sel && trans[1] && wr) bus.HWDATA = wdata;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) bus_cycle(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    bus_cycle(1'b1, 2'b10, 1'b1, addr, size, data);
  endtask

  task automatic rd(input logic [31:0] addr);
    bus_cycle(1'b1, 2'b10, 1'b0, addr, 3'd2, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s0, c0;
    logic        sel, wrb;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [31:0] addr;
    fork
      monitor();
    join_none
    bus.HSEL = 1'b0; bus.HADDR = '0; bus.HWRITE = 1'b0;
    bus.HTRANS = 2'b00; bus.HSIZE = 3'd0; bus.HWDATA = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("reset_wen", 32'(sram_wen), 32'd0);
    rst = 1'b0;
    idle(2);

    // 1: word write then immediate read -> one wait state
    s0 = stall_seen;
    wr(32'h10, 3'd2, 32'hDEADBEEF);
    rd(32'h10);
    idle(2);
    chk("t1_waddr", 32'(obs_waddr), 32'd4);
    chk("t1_wen", 32'(obs_wen), 32'hF);
    chk("t1_rdata", last_rdata, 32'hDEADBEEF);
    chk("t1_waits", 32'(stall_seen - s0), 32'd1);

    // 2: back-to-back byte writes, then word read
    s0 = stall_seen;
    wr(32'h20, 3'd0, {4{8'h11}});
    wr(32'h21, 3'd0, {4{8'h22}});
    wr(32'h22, 3'd0, {4{8'h33}});
    wr(32'h23, 3'd0, {4{8'h44}});
    idle(1);
    chk("t2_wen_seq", 32'(wen_log), 32'h1248);
    rd(32'h20);
    idle(1);
    chk("t2_rdata", last_rdata, 32'h44332211);
    chk("t2_waits", 32'(stall_seen - s0), 32'd0);

    // 3: halfword into the upper lanes
    wr(32'h32, 3'd1, {2{16'hABCD}});
    idle(1);
    chk("t3_wen", 32'(obs_wen), 32'hC);
    rd(32'h30);
    idle(1);
    chk("t3_rdata", last_rdata, 32'hABCD0000);

    // 4: back-to-back reads
    s0 = stall_seen;
    c0 = rdacc_cnt;
    rd(32'h0);
    rd(32'h4);
    rd(32'h8);
    idle(1);
    chk("t4_accesses", 32'(rdacc_cnt - c0), 32'd3);
    chk("t4_waits", 32'(stall_seen - s0), 32'd0);
    chk("t4_rdata", last_rdata, 32'h0);

    // 5: deselected / IDLE / BUSY writes never reach the SRAM
    c0 = cs_cnt;
    bus_cycle(1'b0, 2'b10, 1'b1, 32'h20, 3'd2, 32'hFFFFFFFF);
    bus_cycle(1'b1, 2'b00, 1'b1, 32'h20, 3'd2, 32'hFFFFFFFF);
    bus_cycle(1'b1, 2'b01, 1'b1, 32'h20, 3'd2, 32'hFFFFFFFF);
    idle(1);
    chk("t5_no_access", 32'(cs_cnt - c0), 32'd0);
    rd(32'h20);
    idle(1);
    chk("t5_rdata", last_rdata, 32'h44332211);

    // 6: reset during a write data phase aborts the write
    wr(32'h40, 3'd2, 32'h12345678);
    wr(32'h40, 3'd2, 32'hFFFFFFFF);
    rst = 1'b1;
    #1;
    chk("t6_wen_now", 32'(sram_wen), 32'd0);
    chk("t6_ready_now", 32'(bus.HREADYOUT), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);
    rd(32'h40);
    idle(1);
    chk("t6_rdata", last_rdata, 32'h12345678);

    // Random traffic over a small window so reads hit written words
    for (int unsigned k = 0; k < 600; k++) begin
      sel   = ($urandom_range(0, 9) != 0);
      trans = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 1)) : {1'b1, 1'($urandom_range(0, 1))};
      wrb   = 1'($urandom_range(0, 1));
      size  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      addr  = 32'h100 + 32'($urandom_range(0, 63));
      if (size == 3'd1) addr[0] = 1'b0;
      else if (size != 3'd0) addr[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) addr[31:14] = 18'($urandom);
      bus_cycle(sel, trans, wrb, addr, size, $urandom);
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
